// File: rtl/data_mem_resp.sv
// Memory-side responder for the core's data memory port: one request at a time,
// byte-masked writes and full-word reads on a word-addressed RAM, one response pulse per request.
module data_mem_resp #(
    parameter int Xlen     = 64,
    parameter int MaskBits = Xlen / 8,
    parameter int Depth    = 1024,
    parameter int Latency  = 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                mem_valid_i,
    output logic                mem_ready_o,
    input  logic [Xlen-1:0]     mem_addr_i,
    input  logic [Xlen-1:0]     mem_wdata_i,
    input  logic [MaskBits-1:0] mem_wmask_i,
    output logic [Xlen-1:0]     mem_rdata_o,
    output logic                mem_rvalid_o,
    output logic                mem_err_o
);

    localparam int ByteBits = $clog2(MaskBits);
    localparam int IdxBits  = $clog2(Depth);
    localparam int CntBits  = 5;

    typedef enum logic [1:0] {
        Idle,
        Wait,
        Resp
    } state_e;

    state_e               state_q, state_d;
    logic [CntBits-1:0]   cnt_q, cnt_d;
    logic [Xlen-1:0]      rdata_q, rdata_d;
    logic                 err_q, err_d;

    logic [Xlen-1:0]      ram [Depth];
    logic [IdxBits-1:0]   idx;
    logic                 in_range;
    logic                 is_write;
    logic                 accept;

    assign idx      = mem_addr_i[ByteBits +: IdxBits];
    assign in_range = (mem_addr_i >> (ByteBits + IdxBits)) == '0;
    assign is_write = mem_wmask_i != '0;
    assign accept   = (state_q == Idle) && mem_valid_i;

    // Ready depends only on state, so there is no path from mem_valid_i to mem_ready_o.
    assign mem_ready_o  = rst_ni && (state_q == Idle);
    assign mem_rvalid_o = (state_q == Resp);
    assign mem_rdata_o  = rdata_q;
    assign mem_err_o    = err_q;

    // Writes commit at the accept edge; RAM contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < MaskBits; i++) begin
            if (accept && in_range && mem_wmask_i[i]) begin
                ram[idx][8*i +: 8] <= mem_wdata_i[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            Idle: begin
                if (mem_valid_i) begin
                    if (Latency == 1) begin
                        state_d = Resp;
                    end else begin
                        state_d = Wait;
                        cnt_d   = CntBits'(Latency - 1);
                    end
                    err_d   = ~in_range;
                    rdata_d = (in_range && !is_write) ? ram[idx] : '0;
                end
            end
            Wait: begin
                cnt_d = cnt_q - CntBits'(1);
                if (cnt_q == CntBits'(1)) begin
                    state_d = Resp;
                end
            end
            Resp: begin
                state_d = Idle;
            end
            default: begin
                state_d = Idle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= Idle;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_data_mem_resp.sv
// Self-checking bench for data_mem_resp: a Latency=1 and a Latency=3 instance are
// driven with directed and randomized requests and compared against a word-array model.
module tb_data_mem_resp;

    logic        clk;
    logic        rst_n;
    logic        valid  [2];
    logic        ready  [2];
    logic [63:0] addr   [2];
    logic [63:0] wdata  [2];
    logic [7:0]  wmask  [2];
    logic [63:0] rdata  [2];
    logic        rvalid [2];
    logic        err    [2];

    int tests_run = 0;
    int tests_failed = 0;

    logic [63:0] model [2][1024];
    bit          known [2][1024];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    data_mem_resp #(.Xlen(64), .MaskBits(8), .Depth(1024), .Latency(1)) u_dut_l1 (
        .clk_i(clk), .rst_ni(rst_n), .mem_valid_i(valid[0]), .mem_ready_o(ready[0]),
        .mem_addr_i(addr[0]), .mem_wdata_i(wdata[0]), .mem_wmask_i(wmask[0]),
        .mem_rdata_o(rdata[0]), .mem_rvalid_o(rvalid[0]), .mem_err_o(err[0])
    );

    data_mem_resp #(.Xlen(64), .MaskBits(8), .Depth(1024), .Latency(3)) u_dut_l3 (
        .clk_i(clk), .rst_ni(rst_n), .mem_valid_i(valid[1]), .mem_ready_o(ready[1]),
        .mem_addr_i(addr[1]), .mem_wdata_i(wdata[1]), .mem_wmask_i(wmask[1]),
        .mem_rdata_o(rdata[1]), .mem_rvalid_o(rvalid[1]), .mem_err_o(err[1])
    );

    // Reference behaviour: 8-byte words, 1024 of them, anything at or above 8 KiB is out of range.
    function automatic void model_req(input int d, input logic [63:0] a, input logic [63:0] wd,
                                      input logic [7:0] wm, output logic [63:0] exp_rd,
                                      output logic exp_e, output bit exp_known);
        int w;
        exp_known = 1;
        if (a >= 64'd8192) begin
            exp_rd = '0;
            exp_e  = 1'b1;
            return;
        end
        w     = int'(a / 64'd8);
        exp_e = 1'b0;
        if (wm != 8'h00) begin
            for (int i = 0; i < 8; i++) begin
                if (wm[i]) model[d][w][8*i +: 8] = wd[8*i +: 8];
            end
            if (wm == 8'hFF) known[d][w] = 1;
            exp_rd = '0;
        end else begin
            exp_rd    = model[d][w];
            exp_known = known[d][w];
        end
    endfunction

    // Issue one request and measure the response; lat is negedges after the accept edge, -1 on timeout.
    task automatic do_req(input int d, input logic [63:0] a, input logic [63:0] wd, input logic [7:0] wm,
                          output logic [63:0] rd, output logic e, output int lat, output bit clean);
        int n;
        clean = 1;
        lat   = -1;
        rd    = 'x;
        e     = 1'bx;
        @(negedge clk);
        n = 0;
        while (!ready[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        valid[d] = 1'b1;
        addr[d]  = a;
        wdata[d] = wd;
        wmask[d] = wm;
        @(posedge clk);
        #1;
        valid[d] = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (rvalid[d]) begin
                if (ready[d]) clean = 0;
                lat = k;
                rd  = rdata[d];
                e   = err[d];
                @(negedge clk);
                if (rvalid[d]) clean = 0;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                tests_run++;
                if (ready[d] !== 1'b0 || rvalid[d] !== 1'b0 || rdata[d] !== 64'h0 || err[d] !== 1'b0) begin
                    tests_failed++;
                    $display("[TB] FAIL reset_values dut%0d: ready=%b rvalid=%b rdata=%h err=%b, required 0/0/0/0",
                             d, ready[d], rvalid[d], rdata[d], err[d]);
                end
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            tests_run++;
            if (ready[d] !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL ready_after_reset dut%0d: got %b, required 1", d, ready[d]);
            end
        end
    endtask

    task automatic run_and_check(input string name, input int d, input logic [63:0] a,
                                 input logic [63:0] wd, input logic [7:0] wm);
        logic [63:0] rd, exp_rd;
        logic        e, exp_e;
        int          lat, exp_lat;
        bit          clean, exp_known;
        exp_lat = (d == 0) ? 1 : 3;
        model_req(d, a, wd, wm, exp_rd, exp_e, exp_known);
        do_req(d, a, wd, wm, rd, e, lat, clean);
        tests_run++;
        if (lat !== exp_lat || clean !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL %s timing: latency=%0d clean_pulse=%0b, required latency=%0d clean_pulse=1",
                     name, lat, clean, exp_lat);
        end
        tests_run++;
        if (e !== exp_e || (exp_known && rd !== exp_rd)) begin
            tests_failed++;
            $display("[TB] FAIL %s data: rdata=%h err=%b, required rdata=%h err=%b",
                     name, rd, e, exp_rd, exp_e);
        end
    endtask

    task automatic test_write_read;
        run_and_check("full_write", 0, 64'h40, 64'h1122334455667788, 8'hFF);
        run_and_check("full_read", 0, 64'h40, 64'h0, 8'h00);
        tests_run++;
        if (model[0][8] !== 64'h1122334455667788) begin
            tests_failed++;
            $display("[TB] FAIL model_word8: got %h, required 1122334455667788", model[0][8]);
        end
    endtask

    task automatic test_masked_write;
        run_and_check("masked_write", 0, 64'h44, 64'h000000AB00000000, 8'h10);
        run_and_check("masked_read", 0, 64'h40, 64'h0, 8'h00);
        tests_run++;
        if (model[0][8] !== 64'h112233AB55667788) begin
            tests_failed++;
            $display("[TB] FAIL model_masked: got %h, required 112233AB55667788", model[0][8]);
        end
    endtask

    task automatic test_back_to_back;
        bit exp_rv [64];
        int accepts [$];
        logic [63:0] dummy_rd;
        logic dummy_e;
        bit dummy_k;
        for (int c = 0; c < 64; c++) exp_rv[c] = 0;
        addr[1]  = 64'h28;
        wdata[1] = 64'hCAFEF00DDEADBEEF;
        wmask[1] = 8'hFF;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            tests_run++;
            if (rvalid[1] !== exp_rv[c] || (ready[1] && rvalid[1])) begin
                tests_failed++;
                $display("[TB] FAIL backpressure cycle %0d: rvalid=%b ready=%b, required rvalid=%b and not both",
                         c, rvalid[1], ready[1], exp_rv[c]);
            end
            if (ready[1] === 1'b1) begin
                accepts.push_back(c);
                exp_rv[c + 3] = 1;
            end
            valid[1] = 1'b1;
        end
        @(negedge clk);
        valid[1] = 1'b0;
        model_req(1, 64'h28, 64'hCAFEF00DDEADBEEF, 8'hFF, dummy_rd, dummy_e, dummy_k);
        tests_run++;
        if (accepts.size() != 5 || accepts[0] != 0 || accepts[4] != 16) begin
            tests_failed++;
            $display("[TB] FAIL accept_spacing: %0d accepts, required 5 spaced 4 apart from cycle 0",
                     accepts.size());
        end
        repeat (4) @(negedge clk);
        run_and_check("backpressure_read", 1, 64'h28, 64'h0, 8'h00);
    endtask

    task automatic test_out_of_range;
        run_and_check("seed_word0", 0, 64'h0, 64'h0123456789ABCDEF, 8'hFF);
        run_and_check("oor_write", 0, 64'h2000, 64'hFFFFFFFFFFFFFFFF, 8'hFF);
        run_and_check("word0_unchanged", 0, 64'h0, 64'h0, 8'h00);
        run_and_check("oor_read", 0, 64'h2000, 64'h0, 8'h00);
        run_and_check("oor_high_bit", 0, 64'h8000000000000040, 64'h0, 8'h00);
    endtask

    task automatic test_reset_mid;
        int seen;
        run_and_check("mid_seed", 1, 64'h30, 64'h1111111111111111, 8'hFF);
        @(negedge clk);
        valid[1] = 1'b1;
        addr[1]  = 64'h30;
        wdata[1] = 64'h5A5A5A5A5A5A5A5A;
        wmask[1] = 8'hFF;
        @(posedge clk);
        #1;
        valid[1] = 1'b0;
        model[1][6] = 64'h5A5A5A5A5A5A5A5A;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (rvalid[1] === 1'b1) seen++;
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (rvalid[1] === 1'b1) seen++;
        end
        tests_run++;
        if (seen != 0) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_no_pulse: saw %0d rvalid cycles, required 0", seen);
        end
        run_and_check("after_reset_read", 1, 64'h30, 64'h0, 8'h00);
    endtask

    task automatic test_random;
        logic [63:0] a, wd;
        logic [7:0]  wm;
        for (int d = 0; d < 2; d++) begin
            for (int w = 16; w < 24; w++) begin
                run_and_check("rand_seed", d, 64'(w * 8), {$urandom, $urandom}, 8'hFF);
            end
            for (int n = 0; n < 30; n++) begin
                a  = 64'($urandom_range(16, 23) * 8 + $urandom_range(0, 7));
                wd = {$urandom, $urandom};
                wm = 8'($urandom);
                if ($urandom_range(0, 3) == 0) wm = 8'h00;
                if ($urandom_range(0, 7) == 0) a = a | (64'h1 << $urandom_range(13, 63));
                run_and_check("rand_op", d, a, wd, wm);
            end
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            valid[d] = 1'b0;
            addr[d]  = '0;
            wdata[d] = '0;
            wmask[d] = '0;
            for (int w = 0; w < 1024; w++) begin
                model[d][w] = '0;
                known[d][w] = 0;
            end
        end
        test_reset();
        test_write_read();
        test_masked_write();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
